// File: rtl/gelato_l2_cache_arbiter.sv
// Round-robin share of one L2 request port among NUM_PORTS L1s, one L2 transaction in flight.
// l1_valid->l2_valid 1 cycle, l2_done->l1_done 1 cycle; losers simply hold l1_valid until their l1_done.
module gelato_l2_cache_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 512
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            l1_valid,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] l1_addr,
   output logic [NUM_PORTS-1:0]            l1_done,
   output logic [LINE_WIDTH-1:0]           l1_data,
   output logic                            l2_valid,
   output logic [ADDR_WIDTH-1:0]           l2_addr,
   input  logic                            l2_done,
   input  logic [LINE_WIDTH-1:0]           l2_data
);

   localparam int IDXW = $clog2(NUM_PORTS);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [LINE_WIDTH-1:0] l1_cache_line_t;
   typedef logic [IDXW-1:0]       idx_t;
   typedef logic [IDXW:0]         idx_ext_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   idx_t           grant_q, grant_d;
   idx_t           rr_ptr_q, rr_ptr_d;
   idx_t           mask_idx_q, mask_idx_d;
   logic           mask_vld_q, mask_vld_d;
   addr_t          l2_addr_q, l2_addr_d;
   l1_cache_line_t data_q, data_d;

   logic [NUM_PORTS-1:0] req;
   logic                 sel_found;
   idx_t                 sel_idx;
   idx_ext_t             cand;

   // Modulo-NUM_PORTS add; the extra bit keeps a + b < 2*NUM_PORTS exact.
   function automatic idx_t wrap_add(input idx_t a, input idx_ext_t b);
      idx_ext_t s;
      s = {1'b0, a} + b;
      if (s >= idx_ext_t'(NUM_PORTS)) begin
         s = s - idx_ext_t'(NUM_PORTS);
      end
      return s[IDXW-1:0];
   endfunction

   // The just-served L1 still shows valid in the IDLE cycle after RESP.
   always_comb begin
      req       = l1_valid;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      if (mask_vld_q) begin
         req[mask_idx_q] = 1'b0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, wrap_add(rr_ptr_q, idx_ext_t'(i))};
         if (!sel_found && req[cand[IDXW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDXW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      mask_idx_d = mask_idx_q;
      mask_vld_d = mask_vld_q;
      l2_addr_d  = l2_addr_q;
      data_d     = data_q;
      case (state_q)
         ST_IDLE: begin
            mask_vld_d = 1'b0;
            if (sel_found) begin
               grant_d   = sel_idx;
               l2_addr_d = l1_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (l2_done) begin
               data_d  = l2_data;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rr_ptr_d   = wrap_add(grant_q, idx_ext_t'(1));
            mask_idx_d = grant_q;
            mask_vld_d = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         mask_idx_q <= '0;
         mask_vld_q <= 1'b0;
         l2_addr_q  <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         mask_idx_q <= mask_idx_d;
         mask_vld_q <= mask_vld_d;
         l2_addr_q  <= l2_addr_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      l1_done = '0;
      if (state_q == ST_RESP) begin
         l1_done[grant_q] = 1'b1;
      end
   end

   assign l1_data  = data_q;
   assign l2_valid = (state_q == ST_BUSY);
   assign l2_addr  = l2_addr_q;

endmodule
